// File: rtl/pix_align_pkg.sv
// rtl/pix_align_pkg.sv - shared defaults and FSM states for the pixel align FIFO
package pix_align_pkg;

    localparam int DW_DEF    = 24;
    localparam int DEPTH_DEF = 64;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        RUN        = 1'b1
    } state_t;

endpackage

// File: rtl/pix_align_fifo_if.sv
// rtl/pix_align_fifo_if.sv - stream and status bundle of the pixel align FIFO
interface pix_align_fifo_if #(
    parameter int DW    = 24,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
);
    logic          en;
    logic          wr_vs;
    logic          wr_de;
    logic [DW-1:0] wr_rgb;
    logic          rd_de;
    logic          clr_err;
    logic [DW-1:0] o_rgb;
    logic          o_valid;
    logic [AW:0]   level;
    logic          ovf;
    logic          unf;
    logic          locked;

    modport master (
        output en, wr_vs, wr_de, wr_rgb, rd_de, clr_err,
        input  o_rgb, o_valid, level, ovf, unf, locked
    );

    modport slave (
        input  en, wr_vs, wr_de, wr_rgb, rd_de, clr_err,
        output o_rgb, o_valid, level, ovf, unf, locked
    );
endinterface

// File: rtl/pix_align_ram.sv
// rtl/pix_align_ram.sv - simple dual-port RAM with registered read port
module pix_align_ram #(
    parameter int DW    = 24,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          pixelclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    // Write port; contents are intentionally not reset.
    always_ff @(posedge pixelclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; same-address write returns the old (oldest) entry.
    always_ff @(posedge pixelclk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/pix_align_fifo.sv
// rtl/pix_align_fifo.sv - handshake-driven elastic delay aligning original pixels to a processed stream
module pix_align_fifo
    import pix_align_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           pixelclk,
    input  logic           rst_n,
    pix_align_fifo_if.slave bus
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic          rst_meta;
    logic          rst_sync_n;
    state_t        state_q;
    state_t        state_d;
    logic          vs_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_q;
    logic          valid_q;
    logic          ovf_q;
    logic          unf_q;
    logic          locked_q;
    logic          is_full;
    logic          is_empty;
    logic          push;
    logic          pop;
    logic          flush;
    logic          ovf_evt;
    logic          unf_evt;
    logic [DW-1:0] ram_rdata;

    assign is_full  = (level_q == FULL_LVL);
    assign is_empty = (level_q == '0);

    // Reset asserts immediately, releases two clocks later on a clean edge.
    always_ff @(posedge pixelclk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    // Next state, push/pop decisions and error events; nothing happens while en is low.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (bus.en) begin
            case (state_q)
                WAIT_FRAME: begin
                    flush = 1'b1;
                    if (bus.wr_vs && !vs_q) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    unf_evt = bus.rd_de & is_empty;
                    ovf_evt = bus.wr_de & is_full & ~bus.rd_de;
                    if (unf_evt || ovf_evt) begin
                        flush   = 1'b1;
                        state_d = WAIT_FRAME;
                    end else begin
                        pop  = bus.rd_de & ~is_empty;
                        push = bus.wr_de & (~is_full | pop);
                    end
                end
                default: state_d = WAIT_FRAME;
            endcase
        end
    end

    // State, pointers, occupancy and output-valid registers.
    always_ff @(posedge pixelclk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q  <= WAIT_FRAME;
            locked_q <= 1'b0;
            vs_q     <= 1'b0;
            valid_q  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
        end else if (bus.en) begin
            state_q  <= state_d;
            locked_q <= (state_d == RUN);
            vs_q     <= bus.wr_vs;
            valid_q  <= pop;
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level_q <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                level_q <= level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            end
        end
    end

    // Sticky error flags; a new error outranks a same-cycle clear.
    always_ff @(posedge pixelclk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_evt) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_err) begin
                ovf_q <= 1'b0;
            end
            if (unf_evt) begin
                unf_q <= 1'b1;
            end else if (bus.clr_err) begin
                unf_q <= 1'b0;
            end
        end
    end

    pix_align_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .pixelclk (pixelclk),
        .we       (push),
        .waddr    (wr_ptr),
        .wdata    (bus.wr_rgb),
        .re       (pop),
        .raddr    (rd_ptr),
        .rdata    (ram_rdata)
    );

    // RAM output is masked so unreset or stale contents never leave the block.
    assign bus.o_rgb   = valid_q ? ram_rdata : '0;
    assign bus.o_valid = valid_q;
    assign bus.level   = level_q;
    assign bus.ovf     = ovf_q;
    assign bus.unf     = unf_q;
    assign bus.locked  = locked_q;
endmodule
